seq_checkpoint_checker: RTL and testbench

//   Synthesizable observer for generated designs. It samples a DUT's output

---
 rtl/chk_pkg.sv | 34 +++
 rtl/seq_checkpoint_checker_if.sv | 39 +++
 rtl/ckpt_lane_cmp.sv | 13 +
 rtl/seq_checkpoint_checker.sv | 139 +++++++++++++
 tb/tb_seq_checkpoint_checker.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chk_pkg.sv
// Shared definitions for the checkpoint checker: FSM states, table entry layout
// and a saturating adder used by the error counter.
package chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // Entry layout, LSB first: cycle | mask | expect
    localparam int ENT_CYCLE_LSB = 0;

    function automatic int ent_mask_lsb(input int cyc_w);
        return ENT_CYCLE_LSB + cyc_w;
    endfunction

    function automatic int ent_expect_lsb(input int cyc_w, input int num_ch);
        return ent_mask_lsb(cyc_w) + num_ch;
    endfunction

    function automatic int ent_width(input int cyc_w, input int num_ch, input int data_w);
        return ent_expect_lsb(cyc_w, num_ch) + num_ch * data_w;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/seq_checkpoint_checker_if.sv
// Configuration, observation and status bundle of the checkpoint checker.
// Signal prefixes are from the checker's point of view.
interface seq_checkpoint_checker_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 3,
    parameter int NUM_CKPT = 8,
    parameter int CYC_W    = 16,
    parameter int ERR_W    = 8
);
    localparam int ADDR_W = $clog2(NUM_CKPT);

    logic                     i_start;
    logic [NUM_CH*DATA_W-1:0] i_obs_data;
    logic                     i_cfg_we;
    logic [ADDR_W-1:0]        i_cfg_addr;
    logic [CYC_W-1:0]         i_cfg_cycle;
    logic [NUM_CH-1:0]        i_cfg_mask;
    logic [NUM_CH*DATA_W-1:0] i_cfg_expect;
    logic [ADDR_W:0]          i_cfg_num;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_pass;
    logic [ERR_W-1:0]         o_err_count;
    logic                     o_err_pulse;
    logic [ADDR_W-1:0]        o_first_err;

    modport master (
        output i_start, i_obs_data, i_cfg_we, i_cfg_addr, i_cfg_cycle,
               i_cfg_mask, i_cfg_expect, i_cfg_num,
        input  o_busy, o_done, o_pass, o_err_count, o_err_pulse, o_first_err
    );

    modport slave (
        input  i_start, i_obs_data, i_cfg_we, i_cfg_addr, i_cfg_cycle,
               i_cfg_mask, i_cfg_expect, i_cfg_num,
        output o_busy, o_done, o_pass, o_err_count, o_err_pulse, o_first_err
    );

endinterface

// File: rtl/ckpt_lane_cmp.sv
// Masked equality check of one observed channel against its expected value.
module ckpt_lane_cmp #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_obs,
    input  logic [DATA_W-1:0] i_expect,
    input  logic              i_en,
    output logic              o_mismatch
);

    assign o_mismatch = i_en && (i_obs != i_expect);

endmodule

// File: rtl/seq_checkpoint_checker.sv
// Observer that walks a programmed (cycle, mask, expect) table while counting
// cycles and tallies per-lane mismatches, ordering errors and timeouts.
module seq_checkpoint_checker
    import chk_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 3,
    parameter int NUM_CKPT = 8,
    parameter int CYC_W    = 16,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_checkpoint_checker_if.slave bus
);

    localparam int ADDR_W   = $clog2(NUM_CKPT);
    localparam int NUM_W    = ADDR_W + 1;
    localparam int ENT_W    = ent_width(CYC_W, NUM_CH, DATA_W);
    localparam int MASK_LSB = ent_mask_lsb(CYC_W);
    localparam int EXP_LSB  = ent_expect_lsb(CYC_W, NUM_CH);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_e               r_state;
    chk_state_e               w_stateNext;
    logic [ENT_W-1:0]         r_table [NUM_CKPT];
    logic [NUM_W-1:0]         r_num;
    logic [NUM_W-1:0]         r_idx;
    logic [CYC_W-1:0]         r_cycleCnt;
    logic [ERR_W-1:0]         r_errCount;
    logic [ADDR_W-1:0]        r_firstErr;
    logic                     r_firstErrSet;
    logic                     r_errPulse;

    logic [ENT_W-1:0]         w_entry;
    logic [CYC_W-1:0]         w_entCycle;
    logic [NUM_CH-1:0]        w_entMask;
    logic [NUM_CH*DATA_W-1:0] w_entExpect;
    logic [NUM_CH-1:0]        w_laneMis;
    logic [31:0]              w_misCount;
    logic [31:0]              w_addErr;
    logic                     w_advance;

    assign w_entry     = r_table[r_idx[ADDR_W-1:0]];
    assign w_entCycle  = w_entry[ENT_CYCLE_LSB +: CYC_W];
    assign w_entMask   = w_entry[MASK_LSB +: NUM_CH];
    assign w_entExpect = w_entry[EXP_LSB +: NUM_CH*DATA_W];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            ckpt_lane_cmp #(.DATA_W(DATA_W)) u_lane (
                .i_obs      (bus.i_obs_data[g*DATA_W +: DATA_W]),
                .i_expect   (w_entExpect[g*DATA_W +: DATA_W]),
                .i_en       (w_entMask[g]),
                .o_mismatch (w_laneMis[g])
            );
        end
    endgenerate

    // A saturated cycle counter ends the run; every still-pending entry is one error.
    always_comb begin
        w_stateNext = r_state;
        w_addErr    = '0;
        w_advance   = 1'b0;
        w_misCount  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_misCount = w_misCount + 32'(w_laneMis[i]);
        end
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                if (r_idx == r_num) begin
                    w_stateNext = ST_DONE;
                end else if (r_cycleCnt == CYC_MAX) begin
                    w_stateNext = ST_DONE;
                    w_addErr    = 32'(r_num - r_idx);
                end else if (w_entCycle == r_cycleCnt) begin
                    w_addErr  = w_misCount;
                    w_advance = 1'b1;
                end else if (w_entCycle < r_cycleCnt) begin
                    w_addErr  = 32'd1;
                    w_advance = 1'b1;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            for (int i = 0; i < NUM_CKPT; i++) r_table[i] <= '0;
            r_num         <= '0;
            r_idx         <= '0;
            r_cycleCnt    <= '0;
            r_errCount    <= '0;
            r_firstErr    <= '0;
            r_firstErrSet <= 1'b0;
            r_errPulse    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_errPulse <= 1'b0;
            if (bus.i_cfg_we && (r_state != ST_RUN) && (32'(bus.i_cfg_addr) < NUM_CKPT)) begin
                r_table[bus.i_cfg_addr] <= {bus.i_cfg_expect, bus.i_cfg_mask, bus.i_cfg_cycle};
            end
            if ((r_state != ST_RUN) && bus.i_start) begin
                r_num         <= (bus.i_cfg_num > NUM_W'(NUM_CKPT)) ? NUM_W'(NUM_CKPT) : bus.i_cfg_num;
                r_idx         <= '0;
                r_cycleCnt    <= '0;
                r_errCount    <= '0;
                r_firstErr    <= '0;
                r_firstErrSet <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (r_cycleCnt != CYC_MAX) r_cycleCnt <= r_cycleCnt + 1'b1;
                if (w_advance) r_idx <= r_idx + 1'b1;
                if (w_addErr != '0) begin
                    r_errCount <= ERR_W'(sat_add(32'(r_errCount), w_addErr, 32'(ERR_MAX)));
                    r_errPulse <= 1'b1;
                    if (!r_firstErrSet) begin
                        r_firstErr    <= r_idx[ADDR_W-1:0];
                        r_firstErrSet <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_busy      = (r_state == ST_RUN);
    assign bus.o_done      = (r_state == ST_DONE);
    assign bus.o_pass      = (r_state == ST_DONE) && (r_errCount == '0);
    assign bus.o_err_count = r_errCount;
    assign bus.o_err_pulse = r_errPulse;
    assign bus.o_first_err = r_firstErr;

endmodule

// File: tb/tb_seq_checkpoint_checker.sv
// Scoreboard bench: a default-sized checker plus a narrow one (4-bit cycle
// counter, 2-bit error counter) for the timeout and saturation cases.
module tb_seq_checkpoint_checker;

    localparam int O_BUSY  = 0;
    localparam int O_DONE  = 1;
    localparam int O_PASS  = 2;
    localparam int O_ERR   = 3;
    localparam int O_FIRST = 4;
    localparam int O_PULSE = 5;

    typedef struct {
        int doneEdge;
        int errCount;
        int firstErr;
        int pass;
        int pulses;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    exp_t        sbQueue[$];
    logic [23:0] obsPlan [40];
    bit          wAtStart;
    bit          wMidRun;
    bit          midStart;
    int          wAddr;
    int          wCyc;
    logic [2:0]  wMask;
    logic [23:0] wExp;

    seq_checkpoint_checker_if #(.DATA_W(8), .NUM_CH(3), .NUM_CKPT(8), .CYC_W(16), .ERR_W(8)) busA ();
    seq_checkpoint_checker_if #(.DATA_W(8), .NUM_CH(3), .NUM_CKPT(8), .CYC_W(4),  .ERR_W(2)) busB ();

    seq_checkpoint_checker #(.DATA_W(8), .NUM_CH(3), .NUM_CKPT(8), .CYC_W(16), .ERR_W(8)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    seq_checkpoint_checker #(.DATA_W(8), .NUM_CH(3), .NUM_CKPT(8), .CYC_W(4), .ERR_W(2)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] readOut(input bit useB, input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            O_BUSY:  v = useB ? 32'(busB.o_busy)      : 32'(busA.o_busy);
            O_DONE:  v = useB ? 32'(busB.o_done)      : 32'(busA.o_done);
            O_PASS:  v = useB ? 32'(busB.o_pass)      : 32'(busA.o_pass);
            O_ERR:   v = useB ? 32'(busB.o_err_count) : 32'(busA.o_err_count);
            O_FIRST: v = useB ? 32'(busB.o_first_err) : 32'(busA.o_first_err);
            O_PULSE: v = useB ? 32'(busB.o_err_pulse) : 32'(busA.o_err_pulse);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic driveCfg(input bit useB, input bit we, input int addr, input int cyc,
                            input logic [2:0] mask, input logic [23:0] expv);
        if (useB) begin
            busB.i_cfg_we     = we;
            busB.i_cfg_addr   = 3'(addr);
            busB.i_cfg_cycle  = 4'(cyc);
            busB.i_cfg_mask   = mask;
            busB.i_cfg_expect = expv;
        end else begin
            busA.i_cfg_we     = we;
            busA.i_cfg_addr   = 3'(addr);
            busA.i_cfg_cycle  = 16'(cyc);
            busA.i_cfg_mask   = mask;
            busA.i_cfg_expect = expv;
        end
    endtask

    task automatic driveCtl(input bit useB, input bit start, input int num);
        if (useB) begin
            busB.i_start   = start;
            busB.i_cfg_num = 4'(num);
        end else begin
            busA.i_start   = start;
            busA.i_cfg_num = 4'(num);
        end
    endtask

    task automatic driveObs(input bit useB, input logic [23:0] v);
        if (useB) busB.i_obs_data = v;
        else      busA.i_obs_data = v;
    endtask

    task automatic clearPlan();
        for (int i = 0; i < 40; i++) obsPlan[i] = '0;
    endtask

    task automatic programEntry(input bit useB, input int addr, input int cyc,
                                input logic [2:0] mask, input logic [23:0] expv);
        @(negedge clk);
        driveCfg(useB, 1'b1, addr, cyc, mask, expv);
        @(negedge clk);
        driveCfg(useB, 1'b0, 0, 0, 3'b000, 24'h0);
    endtask

    // Expectation is queued before the run starts; the run is then observed
    // until done and the result is compared against the popped entry.
    task automatic applyStimulus(input string tag, input bit useB, input int num,
                                 input int eDone, input int eErr, input int eFirst,
                                 input int ePass, input int ePulses);
        exp_t e;
        bit   seenDone;
        int   pulses;
        int   doneEdge;
        e.doneEdge = eDone;
        e.errCount = eErr;
        e.firstErr = eFirst;
        e.pass     = ePass;
        e.pulses   = ePulses;
        sbQueue.push_back(e);
        @(negedge clk);
        driveCtl(useB, 1'b1, num);
        if (wAtStart) driveCfg(useB, 1'b1, wAddr, wCyc, wMask, wExp);
        @(negedge clk);
        driveCtl(useB, 1'b0, num);
        driveCfg(useB, 1'b0, 0, 0, 3'b000, 24'h0);
        seenDone = 1'b0;
        pulses   = 0;
        doneEdge = 0;
        for (int k = 0; k < 40 && !seenDone; k++) begin
            driveObs(useB, obsPlan[k]);
            if (k == 0 && wMidRun) driveCfg(useB, 1'b1, wAddr, wCyc, wMask, wExp);
            if (k == 1 && midStart) driveCtl(useB, 1'b1, num);
            @(negedge clk);
            driveCfg(useB, 1'b0, 0, 0, 3'b000, 24'h0);
            driveCtl(useB, 1'b0, num);
            if (k == 0) checkOutput({tag, ".busy"}, readOut(useB, O_BUSY), (num != 0) ? 32'd1 : 32'd0);
            if (readOut(useB, O_PULSE) == 32'd1) pulses++;
            if (readOut(useB, O_DONE) == 32'd1) begin
                seenDone = 1'b1;
                doneEdge = k + 1;
            end
        end
        checkOutput({tag, ".finished"}, 32'(seenDone), 32'd1);
        if (sbQueue.size() == 0) begin
            checkOutput({tag, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput({tag, ".doneEdge"}, 32'(doneEdge), 32'(e.doneEdge));
            checkOutput({tag, ".errCount"}, readOut(useB, O_ERR), 32'(e.errCount));
            checkOutput({tag, ".firstErr"}, readOut(useB, O_FIRST), 32'(e.firstErr));
            checkOutput({tag, ".pass"}, readOut(useB, O_PASS), 32'(e.pass));
            checkOutput({tag, ".pulses"}, 32'(pulses), 32'(e.pulses));
            checkOutput({tag, ".busyEnd"}, readOut(useB, O_BUSY), 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, ".pulseAfter"}, readOut(useB, O_PULSE), 32'd0);
        wAtStart = 1'b0;
        wMidRun  = 1'b0;
        midStart = 1'b0;
        driveObs(useB, 24'h0);
    endtask

    task automatic loadScenarioOne();
        programEntry(1'b0, 0, 1, 3'b011, {8'd0, 8'd12, 8'd36});
        programEntry(1'b0, 1, 2, 3'b111, {8'd48, 8'd12, 8'd48});
        clearPlan();
        obsPlan[1] = {8'd99, 8'd12, 8'd36};
        obsPlan[2] = {8'd48, 8'd12, 8'd48};
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        wAtStart = 1'b0;
        wMidRun  = 1'b0;
        midStart = 1'b0;
        wAddr    = 0;
        wCyc     = 0;
        wMask    = '0;
        wExp     = '0;
        rst_n    = 1'b1;
        driveCtl(1'b0, 1'b0, 0);
        driveCtl(1'b1, 1'b0, 0);
        driveCfg(1'b0, 1'b0, 0, 0, 3'b000, 24'h0);
        driveCfg(1'b1, 1'b0, 0, 0, 3'b000, 24'h0);
        driveObs(1'b0, 24'h0);
        driveObs(1'b1, 24'h0);
        clearPlan();

        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst.busy", readOut(1'b0, O_BUSY), 32'd0);
        checkOutput("rst.done", readOut(1'b0, O_DONE), 32'd0);
        checkOutput("rst.pass", readOut(1'b0, O_PASS), 32'd0);
        checkOutput("rst.err", readOut(1'b0, O_ERR), 32'd0);
        checkOutput("rst.first", readOut(1'b0, O_FIRST), 32'd0);
        checkOutput("rst.pulse", readOut(1'b0, O_PULSE), 32'd0);
        checkOutput("rst.doneB", readOut(1'b1, O_DONE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Matching run; a start pulse mid-run must not restart it
        loadScenarioOne();
        midStart = 1'b1;
        applyStimulus("s1.pass", 1'b0, 2, 4, 0, 0, 1, 0);

        // One lane of entry 1 differs
        clearPlan();
        obsPlan[1] = {8'd99, 8'd12, 8'd36};
        obsPlan[2] = {8'd47, 8'd12, 8'd48};
        applyStimulus("s2.mismatch", 1'b0, 2, 4, 1, 1, 0, 1);

        // Unsorted cycles; entry 0 is written on the same edge as start
        programEntry(1'b0, 1, 3, 3'b000, 24'h0);
        clearPlan();
        obsPlan[5] = {8'd1, 8'd2, 8'd3};
        wAtStart = 1'b1;
        wAddr    = 0;
        wCyc     = 5;
        wMask    = 3'b111;
        wExp     = {8'd1, 8'd2, 8'd3};
        applyStimulus("s3.order", 1'b0, 2, 8, 1, 1, 0, 1);

        clearPlan();
        applyStimulus("s4.empty", 1'b0, 0, 1, 0, 0, 1, 0);

        // Cycle 15 is never checked: the 4-bit counter ends the run there
        programEntry(1'b1, 0, 15, 3'b001, 24'h0);
        clearPlan();
        applyStimulus("s4.timeout", 1'b1, 1, 16, 1, 0, 0, 1);

        // Abort mid-run, then show the table was wiped before reprogramming
        loadScenarioOne();
        @(negedge clk);
        driveCtl(1'b0, 1'b1, 2);
        @(negedge clk);
        driveCtl(1'b0, 1'b0, 2);
        driveObs(1'b0, obsPlan[0]);
        @(negedge clk);
        driveObs(1'b0, obsPlan[1]);
        checkOutput("s5.busyBeforeReset", readOut(1'b0, O_BUSY), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s5.busy", readOut(1'b0, O_BUSY), 32'd0);
        checkOutput("s5.done", readOut(1'b0, O_DONE), 32'd0);
        checkOutput("s5.pass", readOut(1'b0, O_PASS), 32'd0);
        checkOutput("s5.err", readOut(1'b0, O_ERR), 32'd0);
        checkOutput("s5.first", readOut(1'b0, O_FIRST), 32'd0);
        checkOutput("s5.pulse", readOut(1'b0, O_PULSE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        driveObs(1'b0, 24'h0);
        clearPlan();
        applyStimulus("s5.cleared", 1'b0, 2, 3, 1, 1, 0, 1);
        loadScenarioOne();
        applyStimulus("s5.rerun", 1'b0, 2, 4, 0, 0, 1, 0);

        // Every lane of three entries wrong; a write during the run is dropped
        programEntry(1'b1, 0, 1, 3'b111, 24'hFFFFFF);
        programEntry(1'b1, 1, 2, 3'b111, 24'hFFFFFF);
        programEntry(1'b1, 2, 3, 3'b111, 24'hFFFFFF);
        clearPlan();
        wMidRun = 1'b1;
        wAddr   = 2;
        wCyc    = 3;
        wMask   = 3'b111;
        wExp    = 24'h0;
        applyStimulus("s6.saturate", 1'b1, 3, 5, 3, 0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
